// File: rtl/updown_counter_pkg.sv
// updown_counter_pkg: direction encoding and WIDTH/MODULUS legality check shared by the counter files.
// UPDOWN_COUNTER_SATURATE_EN selects saturating instead of wrapping behaviour in updown_next_calc.
package updown_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit cfg_legal(input int w, input longint m);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX) && (m >= 2) && (m <= (64'sd1 <<< w));
    endfunction

endpackage

// File: rtl/updown_next_calc.sv
// updown_next_calc: combinational next-count, terminal-count and clamped load value.
// UPDOWN_COUNTER_SATURATE_EN holds the count at the boundary instead of wrapping.
module updown_next_calc
    import updown_counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_ud,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_next,
    output logic [WIDTH-1:0] o_load_val,
    output logic             o_tc
);

    localparam logic [WIDTH:0] MODV = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] w_up;
    logic [WIDTH:0] w_dn;
    logic           w_dir_up;

    // One extra bit keeps MODULUS = 2**WIDTH free of a spurious carry.
    assign w_up     = {1'b0, i_count} + (WIDTH+1)'(1);
    assign w_dn     = {1'b0, i_count} - (WIDTH+1)'(1);
    assign w_dir_up = (dir_e'(i_ud) == DIR_UP);

    always_comb begin
        o_tc       = w_dir_up ? (w_up == MODV) : w_dn[WIDTH];
        o_load_val = ({1'b0, i_din} >= MODV) ? MAXV[WIDTH-1:0] : i_din;
`ifdef UPDOWN_COUNTER_SATURATE_EN
        o_next     = o_tc ? i_count : (w_dir_up ? w_up[WIDTH-1:0] : w_dn[WIDTH-1:0]);
`else
        o_next     = o_tc ? (w_dir_up ? '0 : MAXV[WIDTH-1:0])
                          : (w_dir_up ? w_up[WIDTH-1:0] : w_dn[WIDTH-1:0]);
`endif
    end

endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: modulo up/down counter with load, tc, wrap pulse and sticky ovf.
// Define UPDOWN_COUNTER_SATURATE_EN to saturate at the boundary instead of wrapping.
module param_updown_counter
    import updown_counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ud,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    if (!cfg_legal(WIDTH, MODULUS)) begin : g_cfg_bad
        $error("param_updown_counter: illegal WIDTH/MODULUS combination");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_val;
    logic             w_tc;
    logic             w_event;

    updown_next_calc #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .i_count    (r_count),
        .i_ud       (ud),
        .i_din      (din),
        .o_next     (w_next),
        .o_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    // A boundary event is an enabled step from tc; load overrides it.
    assign w_event = !load && en && w_tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= load ? w_load_val : (en ? w_next : r_count);
            r_wrap  <= w_event;
            r_ovf   <= w_event || (r_ovf && !clr_ovf);
        end
    end

    assign count = r_count;
    assign tc    = w_tc;
    assign wrap  = r_wrap;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: directed checks of param_updown_counter at WIDTH=4, MODULUS=10.
// Expectations follow UPDOWN_COUNTER_SATURATE_EN when it is defined for the build.
module tb_param_updown_counter;

`ifdef UPDOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, ud, load, clr_ovf;
    logic [3:0] din;
    logic [3:0] count;
    logic       tc, wrap, ovf;
    int         n_tests = 0;
    int         n_fail  = 0;

    param_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .ud      (ud),
        .load    (load),
        .din     (din),
        .clr_ovf (clr_ovf),
        .count   (count),
        .tc      (tc),
        .wrap    (wrap),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e;
        int hold;
        int dn_cnt[5];
        int dn_wrp[5];
        dn_cnt = SAT ? '{2, 1, 0, 0, 0} : '{2, 1, 0, 9, 8};
        dn_wrp = SAT ? '{0, 0, 0, 1, 1} : '{0, 0, 0, 1, 0};
        rst = 1; en = 0; ud = 0; load = 0; din = 0; clr_ovf = 0;
        tick();
        chk("rst_count", count, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_ovf", ovf, 0);
        chk("tc_down_at_0", tc, 1);
        ud = 1;
        #1;
        chk("tc_up_at_0", tc, 0);
        rst = 0; en = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            e = SAT ? ((i + 1 > 9) ? 9 : i + 1) : (i + 1) % 10;
            chk("up_count", count, e);
            chk("up_wrap", wrap, SAT ? (i >= 9) : (i == 9));
            chk("up_ovf", ovf, i >= 9);
            chk("up_tc", tc, e == 9);
        end
        load = 1; din = 3; ud = 0;
        tick();
        chk("load3_count", count, 3);
        chk("load3_wrap", wrap, 0);
        chk("load3_ovf", ovf, 1);
        load = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("dn_count", count, dn_cnt[i]);
            chk("dn_wrap", wrap, dn_wrp[i]);
            chk("dn_tc", tc, dn_cnt[i] == 0);
        end
        en = 0; load = 1; din = 14; ud = 1;
        tick();
        chk("clamp_count", count, 9);
        chk("clamp_wrap", wrap, 0);
        chk("clamp_tc_up", tc, 1);
        din = 5;
        tick();
        chk("load5_count", count, 5);
        din = 2; en = 1;
        tick();
        chk("load_wins_count", count, 2);
        chk("load_wins_wrap", wrap, 0);
        en = 0; din = 9;
        tick();
        chk("load9_ovf_still", ovf, 1);
        load = 0; en = 1; clr_ovf = 1;
        tick();
        chk("setwins_count", count, SAT ? 9 : 0);
        chk("setwins_wrap", wrap, 1);
        chk("setwins_ovf", ovf, 1);
        en = 0;
        tick();
        chk("clr_ovf", ovf, 0);
        chk("clr_wrap", wrap, 0);
        chk("clr_count_hold", count, SAT ? 9 : 0);
        hold = SAT ? 9 : 0;
        clr_ovf = 0;
        tick();
        chk("hold_count", count, hold);
        load = 1; din = 9;
        tick();
        load = 0; en = 1;
        tick();
        chk("pre_rst_wrap", wrap, 1);
        chk("pre_rst_ovf", ovf, 1);
        rst = 1; load = 1; din = 7; clr_ovf = 0;
        tick();
        chk("midrst_count", count, 0);
        chk("midrst_wrap", wrap, 0);
        chk("midrst_ovf", ovf, 0);
        rst = 0; load = 0;
        tick();
        chk("post_rst_count", count, 1);
        chk("post_rst_wrap", wrap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
